// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port shared-ALU arbiter.
// Optional grant statistics are enabled with the ALU_ARB_STATS_EN macro.
package alu_arb_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SLT = 3'b101
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  // Encodings above OP_SLT are reserved and flagged as errors.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'b101);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU function block: (op, a, b) -> (result, err).
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic slt;

  assign slt = ($signed(a) < $signed(b));

  // Function select; ADD/SUB wrap naturally at WIDTH bits.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      default: begin
        result = '0;
        err    = ~is_legal_op(op);
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter and response sequencer for one shared ALU.
// Define ALU_ARB_STATS_EN to add the per-port grant counters.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
`ifdef ALU_ARB_STATS_EN
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`else
  output logic             rsp_err
`endif
);

  arb_state_t       state;
  logic             last_grant;
  logic             any_valid;
  logic             grant_port;
  logic             accept;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  assign any_valid = |req_valid;
  assign accept    = (state == IDLE) && any_valid;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_port = 1'b0;
    if (req_valid == 2'b11) begin
      grant_port = ~last_grant;
    end else if (req_valid[1]) begin
      grant_port = 1'b1;
    end else begin
      grant_port = 1'b0;
    end
  end

  // Ready is only offered to the granted port while idle.
  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      if (grant_port) begin
        req_ready = 2'b10;
      end else begin
        req_ready = 2'b01;
      end
    end else begin
      req_ready = 2'b00;
    end
  end

  // Operand mux feeding the shared function block.
  always_comb begin
    sel_op = req_op0;
    sel_a  = req_a0;
    sel_b  = req_b0;
    if (grant_port) begin
      sel_op = req_op1;
      sel_a  = req_a1;
      sel_b  = req_b1;
    end else begin
      sel_op = req_op0;
      sel_a  = req_a0;
      sel_b  = req_b0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result),
    .err    (alu_err)
  );

  // FSM with registered response; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            last_grant <= grant_port;
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_port;
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_err    <= alu_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-port accept counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (grant_port) begin
        grant_cnt1 <= grant_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        grant_cnt0 <= grant_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (stats checks need ALU_ARB_STATS_EN).
module tb_alu_share_arb;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2:0]    req_op0, req_op1;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0]  rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_STATS_EN
    .rsp_err(rsp_err), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`else
    .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       exp_id_a  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] exp_res_a [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
  logic       exp_zero_a[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       exp_id_b  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] exp_res_b [4] = '{32'h5555_5555, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_FFFF};

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = 3'b000; req_op1 = 3'b000;
    req_a0 = 32'h0; req_b0 = 32'h0; req_a1 = 32'h0; req_b1 = 32'h0;
    tick(); tick();
    check_eq("rst_valid",  64'(rsp_valid),  64'h0);
    check_eq("rst_result", 64'(rsp_result), 64'h0);
    check_eq("rst_zero",   64'(rsp_zero),   64'h0);
    check_eq("rst_err",    64'(rsp_err),    64'h0);
    check_eq("rst_id",     64'(rsp_id),     64'h0);
    check_eq("rst_ready",  64'(req_ready),  64'h0);
`ifdef ALU_ARB_STATS_EN
    check_eq("rst_cnt0", 64'(grant_cnt0), 64'h0);
    check_eq("rst_cnt1", 64'(grant_cnt1), 64'h0);
`endif

    // Port 0 only, AND
    reset = 1'b0;
    req_valid = 2'b01; req_op0 = 3'b000; req_a0 = 32'hFFFF_0000; req_b0 = 32'h0F0F_0F0F;
    #1;
    check_eq("and_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b11;
    req_op0 = 3'b011; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'h0000_0001;
    req_op1 = 3'b101; req_a1 = 32'h8000_0000; req_b1 = 32'h0000_0001;
    check_eq("and_valid",  64'(rsp_valid),  64'h1);
    check_eq("and_id",     64'(rsp_id),     64'h0);
    check_eq("and_result", 64'(rsp_result), 64'h0F0F_0000);
    check_eq("and_zero",   64'(rsp_zero),   64'h0);
    check_eq("and_err",    64'(rsp_err),    64'h0);

    // Backpressure for 5 cycles: response stable, no ready offered
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_ready",  64'(req_ready),  64'h0);
      tick();
      check_eq("hold_valid",  64'(rsp_valid),  64'h1);
      check_eq("hold_result", 64'(rsp_result), 64'h0F0F_0000);
      check_eq("hold_id",     64'(rsp_id),     64'h0);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("release_valid", 64'(rsp_valid), 64'h0);
    check_eq("release_ready", 64'(req_ready), 64'h2);

    // Both valid: grants alternate starting with port 1 (port 0 won last)
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("altA_valid",  64'(rsp_valid),  64'h1);
      check_eq("altA_id",     64'(rsp_id),     64'(exp_id_a[k]));
      check_eq("altA_result", 64'(rsp_result), 64'(exp_res_a[k]));
      check_eq("altA_zero",   64'(rsp_zero),   64'(exp_zero_a[k]));
      tick();
      check_eq("altA_idle", 64'(rsp_valid), 64'h0);
    end

    // Illegal opcode on port 1, held pending
    rsp_ready = 1'b0;
    req_valid = 2'b10; req_op1 = 3'b111; req_a1 = 32'h5; req_b1 = 32'h7;
    tick();
    check_eq("ill_valid",  64'(rsp_valid),  64'h1);
    check_eq("ill_id",     64'(rsp_id),     64'h1);
    check_eq("ill_err",    64'(rsp_err),    64'h1);
    check_eq("ill_result", 64'(rsp_result), 64'h0);
    check_eq("ill_zero",   64'(rsp_zero),   64'h1);

    // Reset during RESP with requests present
    reset = 1'b1; req_valid = 2'b11;
    tick();
    check_eq("rstresp_valid", 64'(rsp_valid), 64'h0);
    check_eq("rstresp_err",   64'(rsp_err),   64'h0);
    reset = 1'b0; rsp_ready = 1'b1;
    req_op0 = 3'b010; req_a0 = 32'hAAAA_5555; req_b0 = 32'hFFFF_0000;
    req_op1 = 3'b100; req_a1 = 32'h0;         req_b1 = 32'h1;
    #1;
    check_eq("tie_ready", 64'(req_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("altB_valid",  64'(rsp_valid),  64'h1);
      check_eq("altB_id",     64'(rsp_id),     64'(exp_id_b[k]));
      check_eq("altB_result", 64'(rsp_result), 64'(exp_res_b[k]));
      check_eq("altB_zero",   64'(rsp_zero),   64'h0);
      check_eq("altB_err",    64'(rsp_err),    64'h0);
      tick();
      check_eq("altB_idle", 64'(rsp_valid), 64'h0);
    end

    // Port 0 alone twice more: counters reach 3/2, then cnt0 wraps
    req_valid = 2'b01;
    tick();
    check_eq("p0a_id", 64'(rsp_id), 64'h0);
`ifdef ALU_ARB_STATS_EN
    check_eq("cnt0_3", 64'(grant_cnt0), 64'h3);
    check_eq("cnt1_2", 64'(grant_cnt1), 64'h2);
`endif
    tick();
    tick();
    check_eq("p0b_id", 64'(rsp_id), 64'h0);
`ifdef ALU_ARB_STATS_EN
    check_eq("cnt0_wrap", 64'(grant_cnt0), 64'h0);
    check_eq("cnt1_keep", 64'(grant_cnt1), 64'h2);
`endif
    req_valid = 2'b00;
    tick();
    check_eq("final_idle", 64'(rsp_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for a single shared 32-bit logic/arithmetic unit. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one request at a time in round-robin order, computes the result, and returns it on a registered response port with backpressure. It sits between the decode/execute control paths and the ALU-function datapath, so that one unit serves both issue slots.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- CNT_W, 16, width of per-port grant counters (used only with ALU_ARB_STATS_EN)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port request ready; bit i = port i
- req_op0, req_op1  in  3  opcode, port 0 / port 1
- req_a0, req_b0, req_a1, req_b1  in  WIDTH  operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  port that issued the response
- rsp_result  out  WIDTH  result
- rsp_zero  out  1  result == 0
- rsp_err  out  1  opcode was illegal
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counters (only with ALU_ARB_STATS_EN)

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed; result is 1 or 0). 110/111 are illegal: result 0, rsp_err=1.
- ADD and SUB wrap modulo 2^WIDTH. No carry or overflow output.
- FSM states:
  - IDLE → RESP when a request is accepted.
  - RESP → IDLE when rsp_valid && rsp_ready.
  - RESP holds otherwise.
- Arbitration happens in IDLE only:
  - Single valid port: that port is granted.
  - Both ports valid: the port ≠ last_grant is granted.
  - last_grant updates on each accept.
- req_ready[i] = (state==IDLE) && (granted port == i). It is combinational from req_valid and last_grant. Both bits are 0 in RESP.
- On accept, rsp_result/zero/err/id are registered from the granted port's inputs.
- Response outputs hold stable while rsp_valid && !rsp_ready.
- A requester may drop req_valid before it is granted. There is no starvation: a continuously valid port is granted within 2 accepts.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_id=0, last_grant=1 (port 0 wins the first tie), counters=0.
- Latency: accept at edge N → rsp_valid=1 from cycle N+1.
- Throughput: at most one op per 2 cycles. A new request cannot be accepted in the same cycle a response is consumed.
- Reset asserted in RESP: the pending response is discarded. rsp_valid is 0 after the reset edge and no handshake completes.
- Requests presented in the same cycle as reset are not accepted.

## Configuration
- ALU_ARB_STATS_EN defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each counter increments by 1 on every accept from its port.
  - Counters wrap at 2^CNT_W.
  - Counters clear only on reset.
- ALU_ARB_STATS_EN undefined: those ports and registers are absent. All other behaviour is identical.

## Structure
- Package alu_arb_pkg holds:
  - alu_op_t: 3-bit enum OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT.
  - arb_state_t: IDLE, RESP.
  - Default WIDTH constant.
- Sub-module alu_core: combinational (op, a, b) → (result, err). It holds all function logic.
- alu_share_arb holds the FSM, arbiter, and response registers.

## Test plan
- Reset, then port 0 only: OP_AND a=0xFFFF0000, b=0x0F0F0F0F → next cycle rsp_valid=1, rsp_id=0, rsp_result=0x0F0F0000, rsp_zero=0.
- Both ports valid continuously, rsp_ready=1 → grants alternate 0,1,0,1. The first grant is port 0 after reset.
- OP_ADD 0xFFFFFFFF+1 → result 0, rsp_zero=1. OP_SLT a=0x80000000, b=1 → result 1.
- rsp_ready held 0 for 5 cycles → response stable, req_ready=00 throughout. Release → IDLE the next cycle.
- Opcode 111 → rsp_err=1, result 0. Reset asserted during RESP → rsp_valid=0 next cycle, and port 0 wins the next tie.
- With ALU_ARB_STATS_EN: 3 accepts on port 0 and 2 on port 1 → grant_cnt0=3, grant_cnt1=2. With CNT_W=2, 4 accepts on one port → that counter wraps to 0.
